cmp_stat_accum: RTL and testbench

CMP_STAT_ACCUM -- requirements
Module: cmp_stat_accum

---
 rtl/cmp_pkg.sv | 14 +
 rtl/cmp_sat_max.sv | 35 +++
 rtl/cmp_stat_accum.sv | 143 ++++++++++++++
 tb/tb_cmp_stat_accum.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator statistics accumulator:
// FSM state encoding and default operand/counter widths.
package cmp_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_sat_max.sv
// Registered running maximum of two DATA_W operands per update, with a
// synchronous clear that wins over the update.
module cmp_sat_max
    import cmp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] max_val
);

    logic [DATA_W-1:0] ab_max;
    logic [DATA_W-1:0] next_max;

    always_comb begin
        ab_max   = (a > b) ? a : b;
        next_max = (ab_max > max_val) ? ab_max : max_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
        end else if (clr) begin
            max_val <= '0;
        end else if (en) begin
            max_val <= next_max;
        end
    end

endmodule

// File: rtl/cmp_stat_accum.sv
// Counts comparator outcomes and tracks the largest operand over an
// N-sample window. Optional flag checking: define CMP_ONEHOT_CHECK_EN.
module cmp_stat_accum
    import cmp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              AgtB,
    input  logic              AltB,
    input  logic              AeqB,
    output logic [CNT_W-1:0]  gt_cnt,
    output logic [CNT_W-1:0]  lt_cnt,
    output logic [CNT_W-1:0]  eq_cnt,
    output logic [DATA_W-1:0] max_val,
    output logic              done,
    input  logic              ack,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid.
    state_t state, state_nxt;

    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] smp_cnt;
    logic             clr_win;
    logic             accept;
    logic             inc_gt, inc_lt, inc_eq;

    assign dbg_state = state;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        clr_win   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_win   = 1'b1;
                    state_nxt = (num_samples == '0) ? REPORT : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && (smp_cnt == n_q - CNT_W'(1))) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                done = 1'b1;
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CMP_ONEHOT_CHECK_EN
    logic flags_onehot;

    always_comb begin
        flags_onehot = ({AgtB, AltB, AeqB} == 3'b100) ||
                       ({AgtB, AltB, AeqB} == 3'b010) ||
                       ({AgtB, AltB, AeqB} == 3'b001);
        inc_gt = AgtB && flags_onehot;
        inc_lt = AltB && flags_onehot;
        inc_eq = AeqB && flags_onehot;
    end

    // Sticky until reset; a bad sample still consumes a slot of the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !flags_onehot) begin
            err <= 1'b1;
        end
    end
`else
    always_comb begin
        inc_gt = AgtB;
        inc_lt = AltB;
        inc_eq = AeqB;
    end

    assign err = 1'b0;
`endif

    // N never exceeds 2^CNT_W-1, so none of these counters can wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q     <= '0;
            smp_cnt <= '0;
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
        end else if (clr_win) begin
            n_q     <= num_samples;
            smp_cnt <= '0;
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
        end else if (accept) begin
            smp_cnt <= smp_cnt + CNT_W'(1);
            if (inc_gt) gt_cnt <= gt_cnt + CNT_W'(1);
            if (inc_lt) lt_cnt <= lt_cnt + CNT_W'(1);
            if (inc_eq) eq_cnt <= eq_cnt + CNT_W'(1);
        end
    end

    cmp_sat_max #(
        .DATA_W(DATA_W)
    ) u_max (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_win),
        .en     (accept),
        .a      (a),
        .b      (b),
        .max_val(max_val)
    );

endmodule

// File: tb/tb_cmp_stat_accum.sv
// Scoreboard bench for cmp_stat_accum: window results are queued when a
// window is launched and checked by a monitor when done rises.
module tb_cmp_stat_accum;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;
    localparam int EXP_W  = 1 + DATA_W + 3 * CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_samples = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] a = '0;
    logic [DATA_W-1:0] b = '0;
    logic              agtb = 1'b0;
    logic              altb = 1'b0;
    logic              aeqb = 1'b0;
    logic [CNT_W-1:0]  gt_cnt, lt_cnt, eq_cnt;
    logic [DATA_W-1:0] max_val;
    logic              done;
    logic              ack = 1'b0;
    logic              err;
    logic [1:0]        dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    int cmp_cnt = 0;
    int bad_cnt = 0;
    logic done_d = 1'b0;
    logic exp_err = 1'b0;

    cmp_stat_accum #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_samples(num_samples),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .AgtB       (agtb),
        .AltB       (altb),
        .AeqB       (aeqb),
        .gt_cnt     (gt_cnt),
        .lt_cnt     (lt_cnt),
        .eq_cnt     (eq_cnt),
        .max_val    (max_val),
        .done       (done),
        .ack        (ack),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst) begin
            done_d = 1'b0;
        end else begin
            if (done && !done_d) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("gt_cnt", int'(gt_cnt), int'(e[CNT_W-1:0]));
                    chk("lt_cnt", int'(lt_cnt), int'(e[2*CNT_W-1:CNT_W]));
                    chk("eq_cnt", int'(eq_cnt), int'(e[3*CNT_W-1:2*CNT_W]));
                    chk("max_val", int'(max_val), int'(e[3*CNT_W+DATA_W-1:3*CNT_W]));
                    chk("err", int'(err), int'(e[EXP_W-1]));
                end
            end
            done_d = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input int g, input int l, input int q, input int m);
        logic [EXP_W-1:0] v;
        v = {exp_err, DATA_W'(m), CNT_W'(q), CNT_W'(l), CNT_W'(g)};
        exp_q.push_back(v);
    endtask

    task automatic start_win(input int n);
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int av, input int bv, input logic g, input logic l, input logic q);
        int waits = 0;
        a = DATA_W'(av);
        b = DATA_W'(bv);
        agtb = g;
        altb = l;
        aeqb = q;
        in_valid = 1'b1;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_cmp(input int av, input int bv);
        send(av, bv, av > bv, av < bv, av == bv);
    endtask

    task automatic finish_window();
        int waits = 0;
        while (!done && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!done) chk("done_timeout", 0, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("done_after_ack", int'(done), 0);
        chk("state_after_ack", int'(dbg_state), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mg, ml, mq, mm;
        int av, bv;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_gt", int'(gt_cnt), 0);
        chk("rst_max", int'(max_val), 0);
        rst = 1'b0;
        @(negedge clk);

        // basic window N=3
        push_exp(1, 1, 1, 7);
        start_win(3);
        send(5, 2, 1'b1, 1'b0, 1'b0);
        send(2, 5, 1'b0, 1'b1, 1'b0);
        send(7, 7, 1'b0, 1'b0, 1'b1);
        finish_window();
        chk("gt_held_idle", int'(gt_cnt), 1);
        chk("max_held_idle", int'(max_val), 7);

        // empty window N=0
        push_exp(0, 0, 0, 0);
        start_win(0);
        chk("n0_done", int'(done), 1);
        chk("n0_in_ready", int'(in_ready), 0);
        finish_window();

        // N=4 with gaps, stray start and ack while running
        push_exp(1, 2, 1, 15);
        start_win(4);
        send_cmp(1, 2);
        repeat (2) @(negedge clk);
        send_cmp(9, 3);
        start = 1'b1;
        ack = 1'b1;
        num_samples = 8'd1;
        @(negedge clk);
        start = 1'b0;
        ack = 1'b0;
        @(negedge clk);
        chk("stray_start_state", int'(dbg_state), 1);
        send_cmp(4, 4);
        repeat (2) @(negedge clk);
        chk("gap_done_early", int'(done), 0);
        chk("gap_in_ready", int'(in_ready), 1);
        send_cmp(0, 15);
        finish_window();

        // illegal flag combination
`ifdef CMP_ONEHOT_CHECK_EN
        exp_err = 1'b1;
        push_exp(0, 1, 0, 5);
`else
        push_exp(1, 1, 1, 5);
`endif
        start_win(2);
        send(5, 2, 1'b1, 1'b0, 1'b1);
        send_cmp(1, 2);
        finish_window();
        chk("err_sticky", int'(err), int'(exp_err));

        // asynchronous reset mid-window
        start_win(5);
        send_cmp(8, 1);
        send_cmp(2, 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_state", int'(dbg_state), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_gt", int'(gt_cnt), 0);
        chk("midrst_lt", int'(lt_cnt), 0);
        chk("midrst_max", int'(max_val), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_err", int'(err), 0);
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_exp(0, 1, 0, 9);
        start_win(1);
        send_cmp(3, 9);
        finish_window();

        // exhaustive pairs: first 255 in one window, (15,15) in a second
        mg = 0; ml = 0; mq = 0; mm = 0;
        for (int i = 0; i < 255; i++) begin
            av = i / 16;
            bv = i % 16;
            if (av > bv) mg++;
            if (av < bv) ml++;
            if (av == bv) mq++;
            if (av > mm) mm = av;
            if (bv > mm) mm = bv;
        end
        push_exp(mg, ml, mq, mm);
        start_win(255);
        for (int i = 0; i < 255; i++) send_cmp(i / 16, i % 16);
        finish_window();
        push_exp(0, 0, 1, 15);
        start_win(1);
        send_cmp(15, 15);
        finish_window();

        repeat (2) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
